// File: rtl/sr_bank_driver.sv
// rtl/sr_bank_driver.sv - write side of an SR flip-flop bank with readback verify and retry
//
// Turns a requested bank value into per-bit set/reset pulses, waits a cycle
// for the bank to settle, compares the Q readback against the target and
// re-drives only the still-differing bits until they match or the retry
// budget runs out.
//
// Ports:
//   clk        sole clock, all state changes on its rising edge
//   rst        synchronous active-high reset
//   tgt_data   requested Q value for the bank
//   tgt_valid  tgt_data is valid
//   tgt_ready  block can accept a target this cycle (IDLE only)
//   q_fb       live Q readback from the bank
//   S          per-bit set request (only non-zero in DRIVE)
//   R          per-bit reset request (only non-zero in DRIVE)
//   done       one-cycle pulse, bank verified equal to target
//   err        one-cycle pulse, bank still mismatched after all retries

module sr_bank_driver #(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] R,
    output logic             done,
    output logic             err
);

    // Counter holds 0..MAX_RETRY; a zero-retry build still needs one bit.
    localparam int RW = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_tgt;
    logic [RW-1:0]    r_retry;
    logic             r_done;
    logic             r_err;

    logic             w_drive;
    logic             w_match;

    assign w_drive = (r_state == DRIVE);
    assign w_match = (q_fb == r_tgt);

    // S and R come from disjoint terms (tgt & ~q versus ~tgt & q), so they
    // can never overlap whatever the state, tgt_reg or q_fb values are.
    assign S = w_drive ? (r_tgt & ~q_fb) : '0;
    assign R = w_drive ? (~r_tgt & q_fb) : '0;

    assign tgt_ready = (r_state == IDLE);
    assign done      = r_done;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tgt   <= '0;
            r_retry <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Also taken in the cycle done/err is high, which gives
                    // back-to-back operation without a bubble.
                    if (tgt_valid) begin
                        r_tgt   <= tgt_data;
                        r_retry <= '0;
                        r_state <= DRIVE;
                    end
                end
                DRIVE: begin
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    r_state <= CHECK;
                end
                CHECK: begin
                    if (w_match) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_retry < RETRY_LAST) begin
                        r_retry <= r_retry + 1'b1;
                        r_state <= DRIVE;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_bank_driver.sv
// tb/tb_sr_bank_driver.sv - directed bench for sr_bank_driver driving a modelled SR bank

module tb_sr_bank_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tgt_data;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [7:0] q_fb;
    logic [7:0] S;
    logic [7:0] R;
    logic       done;
    logic       err;

    logic [7:0] bank;
    logic       preset_en;
    logic [7:0] preset_val;
    logic [7:0] stuck0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sr_bank_driver #(.WIDTH(8), .MAX_RETRY(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_data  (tgt_data),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .q_fb      (q_fb),
        .S         (S),
        .R         (R),
        .done      (done),
        .err       (err)
    );

    // Bank of eight SR flip-flops; stuck0 forces readback bits low.
    always @(posedge clk) begin
        if (preset_en) bank <= preset_val;
        else           bank <= (bank | S) & ~R;
    end
    assign q_fb = bank & ~stuck0;

    task automatic preset(input logic [7:0] v);
        @(negedge clk);
        preset_en  = 1'b1;
        preset_val = v;
        @(negedge clk);
        preset_en  = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        tgt_valid = 1'b1;
        tgt_data  = 8'h55;
        repeat (2) @(negedge clk);
        n_checks++; if (tgt_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", tgt_ready); end
        n_checks++; if (S !== 8'h00) begin n_fail++; $display("FAIL reset_s: got %h want 00", S); end
        n_checks++; if (R !== 8'h00) begin n_fail++; $display("FAIL reset_r: got %h want 00", R); end
        n_checks++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err: got %b want 00", {done, err}); end
        tgt_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        n_checks++; if (tgt_ready !== 1'b1) begin n_fail++; $display("FAIL reset_idle_after: got %b want 1", tgt_ready); end
    endtask

    task automatic test_set_from_clear;
        preset(8'h00);
        n_checks++; if (tgt_ready !== 1'b1) begin n_fail++; $display("FAIL set_c0_ready: got %b want 1", tgt_ready); end
        tgt_valid = 1'b1;
        tgt_data  = 8'hA5;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            tgt_valid = 1'b0;
            tgt_data  = 8'h00;
            if (i == 1) begin
                n_checks++; if (S !== 8'hA5) begin n_fail++; $display("FAIL set_c1_s: got %h want a5", S); end
                n_checks++; if (R !== 8'h00) begin n_fail++; $display("FAIL set_c1_r: got %h want 00", R); end
                n_checks++; if (tgt_ready !== 1'b0) begin n_fail++; $display("FAIL set_c1_ready: got %b want 0", tgt_ready); end
            end
            if (i == 2) begin
                n_checks++; if ({S, R} !== 16'h0000) begin n_fail++; $display("FAIL set_settle_sr: got %h want 0000", {S, R}); end
            end
            if (i == 4) begin
                n_checks++; if ({done, err} !== 2'b10) begin n_fail++; $display("FAIL set_c4_done: got %b want 10", {done, err}); end
                n_checks++; if (q_fb !== 8'hA5) begin n_fail++; $display("FAIL set_c4_q: got %h want a5", q_fb); end
                n_checks++; if (tgt_ready !== 1'b1) begin n_fail++; $display("FAIL set_c4_ready: got %b want 1", tgt_ready); end
            end else begin
                n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL set_done_c%0d: got %b want 0", i, done); end
            end
        end
    endtask

    task automatic test_invert;
        preset(8'hF0);
        tgt_valid = 1'b1;
        tgt_data  = 8'h0F;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            tgt_valid = 1'b0;
            n_checks++; if ((S & R) !== 8'h00) begin n_fail++; $display("FAIL inv_overlap_c%0d: got %h want 00", i, S & R); end
            if (i == 1) begin
                n_checks++; if (S !== 8'h0F) begin n_fail++; $display("FAIL inv_s: got %h want 0f", S); end
                n_checks++; if (R !== 8'hF0) begin n_fail++; $display("FAIL inv_r: got %h want f0", R); end
            end
            if (i == 4) begin
                n_checks++; if ({done, err} !== 2'b10) begin n_fail++; $display("FAIL inv_done: got %b want 10", {done, err}); end
                n_checks++; if (q_fb !== 8'h0F) begin n_fail++; $display("FAIL inv_q: got %h want 0f", q_fb); end
            end
        end
    endtask

    task automatic test_noop;
        preset(8'h3C);
        tgt_valid = 1'b1;
        tgt_data  = 8'h3C;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            tgt_valid = 1'b0;
            if (i == 1) begin
                n_checks++; if ({S, R} !== 16'h0000) begin n_fail++; $display("FAIL noop_sr: got %h want 0000", {S, R}); end
                n_checks++; if (tgt_ready !== 1'b0) begin n_fail++; $display("FAIL noop_busy: got %b want 0", tgt_ready); end
            end
            if (i == 3) begin
                n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL noop_early_done: got %b want 0", done); end
            end
            if (i == 4) begin
                n_checks++; if ({done, err} !== 2'b10) begin n_fail++; $display("FAIL noop_done: got %b want 10", {done, err}); end
            end
        end
    endtask

    task automatic test_stuck_bit;
        logic [7:0] exp_s;
        preset(8'h00);
        stuck0    = 8'h01;
        tgt_valid = 1'b1;
        tgt_data  = 8'h01;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            tgt_valid = 1'b0;
            exp_s = (i == 1 || i == 4 || i == 7 || i == 10) ? 8'h01 : 8'h00;
            n_checks++; if (S !== exp_s) begin n_fail++; $display("FAIL stuck_s_c%0d: got %h want %h", i, S, exp_s); end
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL stuck_done_c%0d: got %b want 0", i, done); end
            n_checks++; if (err !== (i == 13)) begin n_fail++; $display("FAIL stuck_err_c%0d: got %b want %b", i, err, i == 13); end
        end
        stuck0 = 8'h00;
    endtask

    task automatic test_reset_mid_op;
        preset(8'h00);
        tgt_valid = 1'b1;
        tgt_data  = 8'hFF;
        @(negedge clk);
        tgt_valid = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
        tgt_valid = 1'b1;
        tgt_data  = 8'h12;
        @(negedge clk);
        n_checks++; if (tgt_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", tgt_ready); end
        n_checks++; if ({S, R} !== 16'h0000) begin n_fail++; $display("FAIL mid_sr: got %h want 0000", {S, R}); end
        n_checks++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL mid_done_err: got %b want 00", {done, err}); end
        @(negedge clk);
        n_checks++; if (tgt_ready !== 1'b1) begin n_fail++; $display("FAIL mid_no_accept: got %b want 1", tgt_ready); end
        rst       = 1'b0;
        tgt_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if ({done, err, tgt_ready} !== 3'b001) begin n_fail++; $display("FAIL mid_quiet_%0d: got %b want 001", i, {done, err, tgt_ready}); end
        end
    endtask

    task automatic test_back_to_back;
        preset(8'h00);
        tgt_valid = 1'b1;
        tgt_data  = 8'h11;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            tgt_data = 8'h22;
            if (i == 4) begin
                n_checks++; if ({done, tgt_ready} !== 2'b11) begin n_fail++; $display("FAIL b2b_first_done: got %b want 11", {done, tgt_ready}); end
            end
            if (i == 5) begin
                tgt_valid = 1'b0;
                n_checks++; if (S !== 8'h22) begin n_fail++; $display("FAIL b2b_second_s: got %h want 22", S); end
                n_checks++; if (R !== 8'h11) begin n_fail++; $display("FAIL b2b_second_r: got %h want 11", R); end
            end
            if (i == 6 || i == 7) begin
                n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_c%0d: got %b want 0", i, done); end
            end
            if (i == 8) begin
                n_checks++; if ({done, err} !== 2'b10) begin n_fail++; $display("FAIL b2b_second_done: got %b want 10", {done, err}); end
                n_checks++; if (q_fb !== 8'h22) begin n_fail++; $display("FAIL b2b_q: got %h want 22", q_fb); end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        tgt_valid  = 1'b0;
        tgt_data   = 8'h00;
        preset_en  = 1'b0;
        preset_val = 8'h00;
        stuck0     = 8'h00;
        test_reset();
        test_set_from_clear();
        test_invert();
        test_noop();
        test_stuck_bit();
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_bank_driver.md
SR_BANK_DRIVER -- requirements
Module: sr_bank_driver

Purpose: write side of an SR flip-flop bank. Converts a target word into legal per-bit S/R pulses, reads Q back, retries on mismatch.

Interface
REQ-001 Parameter WIDTH, default 8, number of SR flip-flops driven.
REQ-002 Parameter MAX_RETRY, default 3, number of re-drive attempts after the first attempt before an error is flagged.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 tgt_data  input  WIDTH  requested Q value for the bank.
REQ-006 tgt_valid  input  1  tgt_data is valid.
REQ-007 tgt_ready  output  1  block can accept a target this cycle.
REQ-008 q_fb  input  WIDTH  Q readback from the driven SR bank.
REQ-009 S  output  WIDTH  per-bit set request to the bank.
REQ-010 R  output  WIDTH  per-bit reset request to the bank.
REQ-011 done  output  1  one-cycle pulse: bank verified equal to target.
REQ-012 err  output  1  one-cycle pulse: bank still mismatched after all retries.

Function
REQ-013 FSM states: IDLE, DRIVE, SETTLE, CHECK, one cycle each except IDLE.
REQ-014 tgt_ready is high only in IDLE, decoded combinationally from state.
REQ-015 Handshake: tgt_valid and tgt_ready high at a posedge captures tgt_data into tgt_reg, clears retry_cnt and moves to DRIVE.
REQ-016 tgt_valid without tgt_ready is ignored; tgt_data is not required to hold after acceptance.
REQ-017 In DRIVE: S = tgt_reg & ~q_fb and R = ~tgt_reg & q_fb. Both are combinational from state, tgt_reg and live q_fb. Next state is SETTLE.
REQ-018 In every state other than DRIVE, S and R are all zeros.
REQ-019 Invariant: S & R is zero in every cycle, including during and immediately after reset.
REQ-020 Bits where q_fb already equals tgt_reg get S=R=0; a fully matching target still passes through DRIVE, SETTLE and CHECK.
REQ-021 SETTLE drives no pulses and always moves to CHECK.
REQ-022 CHECK, q_fb == tgt_reg: go to IDLE and assert done in the following cycle.
REQ-023 CHECK, mismatch with retry_cnt < MAX_RETRY: increment retry_cnt and go to DRIVE. Only still-differing bits are pulsed again.
REQ-024 CHECK, mismatch with retry_cnt == MAX_RETRY: go to IDLE and assert err in the following cycle.
REQ-025 done and err are registered, high for exactly one cycle, mutually exclusive, and coincide with the first IDLE cycle.
REQ-026 A new target may be accepted in the same cycle that done or err is high (back-to-back operation).
REQ-027 Latency: acceptance in cycle c0 gives DRIVE c1, SETTLE c2, CHECK c3 and done in c4. Each retry adds 3 cycles.
REQ-028 Worst case: err in cycle c0 + 3*(MAX_RETRY+1) + 1.
REQ-029 retry_cnt width is clog2(MAX_RETRY+1), minimum 1 bit; it never wraps.

Reset
REQ-030 rst high at a posedge forces: state IDLE, tgt_reg 0, retry_cnt 0, done 0, err 0.
REQ-031 Reset output values: S=0, R=0, tgt_ready=1 in the cycle after reset.
REQ-032 rst dominates tgt_valid in the same cycle; no target is accepted while rst is high.
REQ-033 Reset in any non-IDLE state aborts the operation with no done or err pulse. S and R return to zero in the next cycle.

Verification
Bench models the bank as WIDTH SR flip-flops on clk, fed by S/R and driving q_fb. WIDTH=8, MAX_RETRY=3.
REQ-034 Set from clear: reset, q_fb=8'h00, accept 8'hA5 at c0 -> c1 S=8'hA5 R=8'h00; c4 done=1, err=0; q_fb=8'hA5.
REQ-035 Invert: q_fb=8'hF0, accept 8'h0F -> DRIVE S=8'h0F R=8'hF0; S&R=0 in every cycle; done at c4.
REQ-036 No-op: q_fb=8'h3C, accept 8'h3C -> DRIVE S=R=8'h00; done at c4.
REQ-037 Stuck bit: bench forces q_fb[0]=0, accept 8'h01 -> S[0]=1 in c1, c4, c7 and c10; err at c13; no done pulse.
REQ-038 Reset mid-op: accept 8'hFF, assert rst in c2 -> c3 state IDLE, S=R=0, tgt_ready=1; no done or err. tgt_valid held high during rst is not accepted.
REQ-039 Streaming: tgt_valid held high with 8'h11 then 8'h22 -> second acceptance at c4, concurrent with first done; second done at c8.
